receiver_timing_and_shift_register: RTL

Serial-to-parallel UART receiver. It is the receive-side counterpart of the UART transmitter and uses the same line-control inputs (PEN, EPS, SP, STB, WLS).

- Oversamples the `rx` line at OS_RATE clocks per bit and validates the start bit at mid-bit.
- Shifts in 5–8 data bits LSB-first, then checks parity and the stop bit.
- Presents the character with a ready/acknowledge handshake and sticky error flags.
- Sits between the `rx` pin and the register/host interface of the UART.

---
 rtl/receiver_timing_and_shift_register_if.sv | 30 +++
 rtl/receiver_timing_and_shift_register.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/receiver_timing_and_shift_register_if.sv
// Serial line, line-control and host handshake signals of the UART receiver.
// The master drives the line and configuration; the slave (receiver) returns the character and status.
interface receiver_timing_and_shift_register_if;
    logic       rx;
    logic       PEN;
    logic       EPS;
    logic       SP;
    logic       STB;
    logic [1:0] WLS;
    logic       rd_ack;
    logic [7:0] data_out;
    logic       data_ready;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;
    logic       break_int;
    logic       busy;

    modport master (
        output rx, PEN, EPS, SP, STB, WLS, rd_ack,
        input  data_out, data_ready, parity_error, framing_error,
               overrun_error, break_int, busy
    );

    modport slave (
        input  rx, PEN, EPS, SP, STB, WLS, rd_ack,
        output data_out, data_ready, parity_error, framing_error,
               overrun_error, break_int, busy
    );
endinterface

// File: rtl/receiver_timing_and_shift_register.sv
// UART receiver: oversampled start detection, LSB-first shift-in, parity/stop checks,
// break detection and a ready/ack handshake with sticky error flags.
module receiver_timing_and_shift_register #(
    parameter int unsigned OS_RATE = 16
) (
    input  logic                                 m_clk,
    input  logic                                 reset,
    receiver_timing_and_shift_register_if.slave  bus
);
    localparam int unsigned      CNT_W    = $clog2(OS_RATE);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OS_RATE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [1:0]       r_wls;
    logic             r_pen;
    logic             r_eps;
    logic             r_sp;
    logic             r_all_zero;
    logic             r_par_err;
    logic [7:0]       r_data_out;
    logic             r_data_ready;
    logic             r_parity_error;
    logic             r_framing_error;
    logic             r_overrun_error;
    logic             r_break_int;
    logic             r_busy;
    logic             w_frame_start;
    logic             w_start_ok;
    logic             w_data_smp;
    logic             w_par_smp;
    logic             w_stop_smp;
    logic             w_brk;
    logic             w_par_exp;
    logic             w_unused;

    // Only the first stop bit is checked, so the stop-bit count has no effect here.
    assign w_unused = bus.STB;

    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_start_ok    = 1'b0;
        w_data_smp    = 1'b0;
        w_par_smp     = 1'b0;
        w_stop_smp    = 1'b0;
        w_brk         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_next  = S_START;
                    w_frame_start = 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    if (w_rx_s) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_DATA;
                        w_start_ok   = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_data_smp = 1'b1;
                    if (r_bit_idx == 3'(r_wls) + 3'd4)
                        w_state_next = r_pen ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (r_cnt == CNT_LAST) begin
                    w_par_smp    = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_stop_smp = 1'b1;
                    if (r_all_zero && !w_rx_s) begin
                        w_brk        = 1'b1;
                        w_state_next = S_BRK_WAIT;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_BRK_WAIT: begin
                if (w_rx_s) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_par_exp = r_sp ? ~r_eps : (r_eps ? ^r_shift : ~(^r_shift));

    // Bit-period counter, shift register and the configuration captured at the start edge.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_wls      <= 2'd0;
            r_pen      <= 1'b0;
            r_eps      <= 1'b0;
            r_sp       <= 1'b0;
            r_all_zero <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE || r_state == S_BRK_WAIT || w_start_ok || r_cnt == CNT_LAST)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_frame_start) begin
                r_bit_idx  <= 3'd0;
                r_shift    <= 8'd0;
                r_wls      <= bus.WLS;
                r_pen      <= bus.PEN;
                r_eps      <= bus.EPS;
                r_sp       <= bus.SP;
                r_all_zero <= 1'b1;
                r_par_err  <= 1'b0;
            end
            if (w_data_smp) begin
                r_shift[r_bit_idx] <= w_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
            if (w_data_smp || w_par_smp || w_stop_smp)
                r_all_zero <= r_all_zero & ~w_rx_s;
            if (w_par_smp)
                r_par_err <= (w_rx_s != w_par_exp);
        end
    end

    // Completion beats a simultaneous rd_ack, so a fresh character is never lost.
    always_ff @(posedge m_clk or negedge reset) begin
        if (!reset) begin
            r_data_out      <= 8'd0;
            r_data_ready    <= 1'b0;
            r_parity_error  <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
            r_break_int     <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            if (w_stop_smp) begin
                r_data_ready    <= 1'b1;
                r_parity_error  <= r_par_err;
                r_framing_error <= ~w_rx_s;
                r_overrun_error <= r_data_ready & ~bus.rd_ack;
                if (w_brk) begin
                    r_data_out  <= 8'd0;
                    r_break_int <= 1'b1;
                end else begin
                    r_data_out  <= r_shift;
                    r_break_int <= r_break_int & ~bus.rd_ack;
                end
            end else if (bus.rd_ack) begin
                r_data_ready    <= 1'b0;
                r_parity_error  <= 1'b0;
                r_framing_error <= 1'b0;
                r_overrun_error <= 1'b0;
                r_break_int     <= 1'b0;
            end
            r_busy <= (w_state_next != S_IDLE);
        end
    end

    assign bus.data_out      = r_data_out;
    assign bus.data_ready    = r_data_ready;
    assign bus.parity_error  = r_parity_error;
    assign bus.framing_error = r_framing_error;
    assign bus.overrun_error = r_overrun_error;
    assign bus.break_int     = r_break_int;
    assign bus.busy          = r_busy;
endmodule
